// File: rtl/shift_operand_decoder.sv
// Purpose : decodes the ARM data-processing operand-2 field into barrel-shifter controls.
//           Register-specified shifts read Rs through a synchronous register-file port.
// Latency : immediate and bypass results are valid the cycle after accept.
//           The register-shift path adds FETCH_RS and CAPTURE, so it is valid three cycles after in_valid.
// Backpressure: one instruction is in flight at a time. ISSUE holds every output until out_ready.
//               in_ready is low outside IDLE, so in_valid is ignored there.
// Ports:
//   Clk, Reset                 clock and synchronous active-high reset
//   in_valid/in_ready          instruction handshake; Instr, rm_data and c_flag are sampled on accept
//   rs_addr/rs_rd_en/rs_data   Rs read port; data returns the cycle after rs_rd_en
//   out_valid/out_ready        result handshake
//   Operand, Amount, IR, ISO,  shifter controls; EN is active-low (1 = bypass)
//   EN, CIn, RRX
module shift_operand_decoder #(
  parameter int RS_AMT_BITS = 8,
  parameter bit DP_CHECK    = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Instr,
  input  logic [31:0] rm_data,
  input  logic        c_flag,
  output logic [3:0]  rs_addr,
  output logic        rs_rd_en,
  input  logic [31:0] rs_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Operand,
  output logic [11:0] Amount,
  output logic [1:0]  IR,
  output logic        ISO,
  output logic        EN,
  output logic        CIn,
  output logic        RRX
);

  typedef enum logic [1:0] {IDLE, FETCH_RS, CAPTURE, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [31:0] operand_nxt;
  logic [11:0] amount_nxt;
  logic [1:0]  ir_nxt;
  logic        iso_nxt, en_nxt, cin_nxt, rrx_nxt;
  logic        out_valid_nxt, rs_rd_en_nxt;
  logic [3:0]  rs_addr_nxt;
  logic [RS_AMT_BITS-1:0] rs_amt;

  // Instruction bits outside operand 2 and the high Rs bits do not affect the shifter.
  logic unused_bits;
  assign unused_bits = ^{Instr[31:28], Instr[24:12], rs_data};

  assign rs_amt   = rs_data[RS_AMT_BITS-1:0];
  assign in_ready = (state == IDLE) && !Reset;

  always_comb begin
    state_nxt     = state;
    operand_nxt   = Operand;
    amount_nxt    = Amount;
    ir_nxt        = IR;
    iso_nxt       = ISO;
    en_nxt        = EN;
    cin_nxt       = CIn;
    rrx_nxt       = RRX;
    out_valid_nxt = out_valid;
    rs_addr_nxt   = rs_addr;
    rs_rd_en_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          operand_nxt = rm_data;
          cin_nxt     = c_flag;
          iso_nxt     = 1'b0;
          rrx_nxt     = 1'b0;
          if (DP_CHECK && (Instr[27:26] != 2'b00)) begin
            // Not a data-processing instruction, so the shifter passes rm_data through.
            amount_nxt    = 12'd0;
            ir_nxt        = 2'b00;
            en_nxt        = 1'b1;
            out_valid_nxt = 1'b1;
            state_nxt     = ISSUE;
          end else if (Instr[25]) begin
            operand_nxt   = {24'b0, Instr[7:0]};
            amount_nxt    = {7'b0, Instr[11:8], 1'b0};
            ir_nxt        = 2'b11;
            iso_nxt       = 1'b1;
            en_nxt        = (Instr[11:8] == 4'd0);
            out_valid_nxt = 1'b1;
            state_nxt     = ISSUE;
          end else if (!Instr[4]) begin
            ir_nxt        = Instr[6:5];
            amount_nxt    = {7'b0, Instr[11:7]};
            en_nxt        = 1'b0;
            out_valid_nxt = 1'b1;
            state_nxt     = ISSUE;
            // A zero immediate encodes LSR/ASR #32 and RRX. Only LSL #0 is a real no-op.
            if (Instr[11:7] == 5'd0) begin
              case (Instr[6:5])
                2'b00: en_nxt = 1'b1;
                2'b11: begin
                  rrx_nxt    = 1'b1;
                  amount_nxt = 12'd1;
                end
                default: amount_nxt = 12'd32;
              endcase
            end
          end else begin
            // The amount is not known until Rs returns, so stay in bypass until CAPTURE.
            ir_nxt       = Instr[6:5];
            amount_nxt   = 12'd0;
            en_nxt       = 1'b1;
            rs_addr_nxt  = Instr[11:8];
            rs_rd_en_nxt = 1'b1;
            state_nxt    = FETCH_RS;
          end
        end
      end
      FETCH_RS: state_nxt = CAPTURE;
      CAPTURE: begin
        amount_nxt    = 12'(rs_amt);
        en_nxt        = (rs_amt == '0);
        out_valid_nxt = 1'b1;
        state_nxt     = ISSUE;
      end
      ISSUE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Operand   <= 32'd0;
      Amount    <= 12'd0;
      IR        <= 2'b00;
      ISO       <= 1'b0;
      EN        <= 1'b1;
      CIn       <= 1'b0;
      RRX       <= 1'b0;
      out_valid <= 1'b0;
      rs_addr   <= 4'd0;
      rs_rd_en  <= 1'b0;
    end else begin
      state     <= state_nxt;
      Operand   <= operand_nxt;
      Amount    <= amount_nxt;
      IR        <= ir_nxt;
      ISO       <= iso_nxt;
      EN        <= en_nxt;
      CIn       <= cin_nxt;
      RRX       <= rrx_nxt;
      out_valid <= out_valid_nxt;
      rs_addr   <= rs_addr_nxt;
      rs_rd_en  <= rs_rd_en_nxt;
    end
  end

endmodule

// File: tb/tb_shift_operand_decoder.sv
// Purpose : scoreboard bench for shift_operand_decoder.
// Stimulus drives inputs 1 ns after the rising edge. Samples are taken on the falling edge.
// The monitor pops the expected controls whenever out_valid && out_ready.
module tb_shift_operand_decoder;

  typedef struct packed {
    logic [31:0] op;
    logic [11:0] amt;
    logic [1:0]  ir;
    logic        iso;
    logic        en;
    logic        cin;
    logic        rrx;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset, in_valid, in_ready, c_flag, rs_rd_en, out_valid, out_ready;
  logic [31:0] Instr, rm_data, rs_data, Operand;
  logic [3:0]  rs_addr;
  logic [11:0] Amount;
  logic [1:0]  IR;
  logic        ISO, EN, CIn, RRX;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  shift_operand_decoder #(.RS_AMT_BITS(8), .DP_CHECK(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .rm_data(rm_data), .c_flag(c_flag),
    .rs_addr(rs_addr), .rs_rd_en(rs_rd_en), .rs_data(rs_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .Operand(Operand), .Amount(Amount), .IR(IR), .ISO(ISO), .EN(EN), .CIn(CIn), .RRX(RRX)
  );

  function automatic exp_t mk(input logic [31:0] op, input logic [11:0] amt, input logic [1:0] ir,
                              input logic iso, input logic en, input logic cin, input logic rrx);
    exp_t e;
    e = {op, amt, ir, iso, en, cin, rrx};
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge Clk) begin
    exp_t act, e;
    if (!Reset && out_valid && out_ready) begin
      act = {Operand, Amount, IR, ISO, EN, CIn, RRX};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h expected=<none>", act);
      end else begin
        e = q.pop_front();
        if (act !== e) begin
          bad++;
          $display("FAIL result got op=%h amt=%0d ir=%b iso=%b en=%b cin=%b rrx=%b expected op=%h amt=%0d ir=%b iso=%b en=%b cin=%b rrx=%b",
                   act.op, act.amt, act.ir, act.iso, act.en, act.cin, act.rrx,
                   e.op, e.amt, e.ir, e.iso, e.en, e.cin, e.rrx);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Called on a falling edge.
  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rs_rd_en"},  32'(rs_rd_en),  32'd0);
    chk({tag, "_rs_addr"},   32'(rs_addr),   32'd0);
    chk({tag, "_operand"},   Operand,        32'd0);
    chk({tag, "_amount"},    32'(Amount),    32'd0);
    chk({tag, "_ir"},        32'(IR),        32'd0);
    chk({tag, "_iso"},       32'(ISO),       32'd0);
    chk({tag, "_en"},        32'(EN),        32'd1);
    chk({tag, "_cin"},       32'(CIn),       32'd0);
    chk({tag, "_rrx"},       32'(RRX),       32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
  endtask

  // Entered and left at posedge+1. On return, the last edge passed was the accept edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] rm, input logic c,
                      input bit push, input exp_t e);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    Instr    = ins;
    rm_data  = rm;
    c_flag   = c;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge Clk);
      if (in_ready) done = 1'b1;
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b0;
    if (push && done) q.push_back(e);
    chk("accept", 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge Clk);
      if (in_ready) done = 1'b1;
    end
    @(posedge Clk);
    #1;
    chk("return_idle", 32'(done), 32'd1);
  endtask

  task automatic imm_txn(input string name, input logic [31:0] ins, input logic [31:0] rm,
                         input logic c, input exp_t e);
    send(ins, rm, c, 1'b1, e);
    @(negedge Clk);
    chk({name, "_valid_lat1"}, 32'(out_valid), 32'd1);
    chk({name, "_no_rd"}, 32'(rs_rd_en), 32'd0);
    wait_idle();
  endtask

  task automatic reg_txn(input string name, input logic [31:0] ins, input logic [31:0] rm,
                         input logic c, input logic [31:0] rsv, input logic [3:0] exp_addr, input exp_t e);
    rs_data = 32'hDEADBEEF;
    send(ins, rm, c, 1'b1, e);
    @(negedge Clk);
    chk({name, "_rd_en1"}, 32'(rs_rd_en), 32'd1);
    chk({name, "_rs_addr"}, 32'(rs_addr), 32'(exp_addr));
    chk({name, "_valid_c1"}, 32'(out_valid), 32'd0);
    @(posedge Clk);
    #1;
    rs_data = rsv;
    @(negedge Clk);
    chk({name, "_rd_en2"}, 32'(rs_rd_en), 32'd0);
    chk({name, "_valid_c2"}, 32'(out_valid), 32'd0);
    @(posedge Clk);
    #1;
    rs_data = 32'hDEADBEEF;
    @(negedge Clk);
    chk({name, "_valid_c3"}, 32'(out_valid), 32'd1);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit qdone;
    Reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Instr     = 32'd0;
    rm_data   = 32'd0;
    c_flag    = 1'b0;
    rs_data   = 32'hDEADBEEF;
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    check_reset_vals("reset");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1;

    // Immediate rotate, immediate shifts and their zero-amount encodings.
    imm_txn("rot8",   32'hE3A004FF, 32'h11111111, 1'b0, mk(32'h000000FF, 12'd8,  2'b11, 1, 0, 0, 0));
    imm_txn("rot0",   32'hE3A000AB, 32'h11111111, 1'b1, mk(32'h000000AB, 12'd0,  2'b11, 1, 1, 1, 0));
    imm_txn("lsl2",   32'hE1A00101, 32'h00000001, 1'b1, mk(32'h00000001, 12'd2,  2'b00, 0, 0, 1, 0));
    imm_txn("lsr32",  32'hE1A00021, 32'h80000000, 1'b0, mk(32'h80000000, 12'd32, 2'b01, 0, 0, 0, 0));
    imm_txn("asr32",  32'hE1A00041, 32'h80000001, 1'b1, mk(32'h80000001, 12'd32, 2'b10, 0, 0, 1, 0));
    imm_txn("rrx",    32'hE1A00061, 32'hF0F0F0F0, 1'b1, mk(32'hF0F0F0F0, 12'd1,  2'b11, 0, 0, 1, 1));
    imm_txn("lsl0",   32'hE1A00001, 32'hAAAA5555, 1'b0, mk(32'hAAAA5555, 12'd0,  2'b00, 0, 1, 0, 0));
    imm_txn("bypass", 32'hE5900000, 32'h12345678, 1'b1, mk(32'h12345678, 12'd0,  2'b00, 0, 1, 1, 0));

    // Register-specified shifts: a nonzero low byte, a zero low byte and an amount of 32 or more.
    reg_txn("rs5",  32'hE1A00211, 32'h00000001, 1'b0, 32'h00000105, 4'd2, mk(32'h00000001, 12'd5,  2'b00, 0, 0, 0, 0));
    reg_txn("rs0",  32'hE1A00211, 32'h00000001, 1'b1, 32'h00000100, 4'd2, mk(32'h00000001, 12'd0,  2'b00, 0, 1, 1, 0));
    reg_txn("rs40", 32'hE1A00331, 32'hCAFEF00D, 1'b0, 32'hFFFFFF28, 4'd3, mk(32'hCAFEF00D, 12'd40, 2'b01, 0, 0, 0, 0));

    // Backpressure: ISSUE must hold with in_valid toggling.
    out_ready = 1'b0;
    send(32'hE3A00F01, 32'h0, 1'b1, 1'b1, mk(32'h00000001, 12'd30, 2'b11, 1, 0, 1, 0));
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      Instr    = $urandom;
      rm_data  = $urandom;
      c_flag   = i[0];
      @(negedge Clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_operand", Operand, 32'h00000001);
      chk("hold_amount", 32'(Amount), 32'd30);
      chk("hold_cin", 32'(CIn), 32'd1);
      @(posedge Clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge Clk);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_valid", 32'(out_valid), 32'd0);
    @(posedge Clk);
    #1;

    // Reset while in FETCH_RS.
    send(32'hE1A00211, 32'h00000007, 1'b1, 1'b0, '0);
    Reset = 1'b1;
    @(negedge Clk);
    @(posedge Clk);
    #1;
    @(negedge Clk);
    check_reset_vals("mid_fetch_reset");
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("ready_after_mid_reset", 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1;
    imm_txn("post_reset", 32'hE1A00101, 32'h00000003, 1'b0, mk(32'h00000003, 12'd2, 2'b00, 0, 0, 0, 0));

    qdone = 1'b0;
    for (int i = 0; i < 20 && !qdone; i++) begin
      @(negedge Clk);
      if (q.size() == 0) qdone = 1'b1;
    end
    chk("scoreboard_drained", 32'(qdone), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
